// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit-counter branch predictor with tagged targets, EX-stage
// training, same-cycle misprediction redirect and saturating statistics.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  input  logic        stat_clr,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);
  localparam int INDEX_W = $clog2(ENTRIES);

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mis_cnt_q, mis_cnt_d;

  logic [INDEX_W-1:0] lk_idx, ex_idx;
  logic [TAG_W-1:0]   lk_tag, ex_tag;
  logic               lk_hit, ex_hit;
  logic               upd, mispredict;
  logic [1:0]         ctr_d;

  // PC bits outside index/tag only feed the +4 adders; keep the lint quiet.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc, ex_pc};

  assign lk_idx = if_pc[INDEX_W+1:2];
  assign lk_tag = if_pc[INDEX_W+TAG_W+1:INDEX_W+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign pred_taken  = lk_hit && ctr_q[lk_idx][1];
  assign pred_target = pred_taken ? target_q[lk_idx] : if_pc + 32'd4;

  assign ex_idx = ex_pc[INDEX_W+1:2];
  assign ex_tag = ex_pc[INDEX_W+TAG_W+1:INDEX_W+2];
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign upd    = ex_valid && ex_branch;

  assign mispredict  = upd && ((ex_taken != ex_pred_taken) ||
                               (ex_taken && (ex_pred_target != ex_target)));
  assign redirect    = mispredict;
  assign redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;

  always_comb begin
    ctr_d = ctr_q[ex_idx];
    if (ex_taken) begin
      if (ctr_q[ex_idx] != 2'b11) ctr_d = ctr_q[ex_idx] + 2'd1;
    end else begin
      if (ctr_q[ex_idx] != 2'b00) ctr_d = ctr_q[ex_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (upd) begin
      if (ex_hit) begin
        ctr_q[ex_idx] <= ctr_d;
        if (ex_taken) target_q[ex_idx] <= ex_target;
      end else if (ex_taken) begin
        // Taken miss evicts whatever aliases into this slot.
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= ex_target;
        ctr_q[ex_idx]    <= 2'b10;
      end
    end
  end

  always_comb begin
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (stat_clr) begin
      br_cnt_d  = '0;
      mis_cnt_d = '0;
    end else begin
      if (upd && (br_cnt_q != 32'hFFFF_FFFF))         br_cnt_d  = br_cnt_q + 32'd1;
      if (mispredict && (mis_cnt_q != 32'hFFFF_FFFF)) mis_cnt_d = mis_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign stat_branches    = br_cnt_q;
  assign stat_mispredicts = mis_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed plus randomized checks of branch_predictor against a table model
// built from the predictor's rules with plain integer arithmetic.
module tb_branch_predictor;
  localparam int ENTRIES = 16;
  localparam int TAG_W   = 8;
  localparam int IW      = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_branch, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stat_clr;
  logic [31:0] stat_branches, stat_mispredicts;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  bit [31:0]   m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  bit [31:0]   m_br, m_mis;

  branch_predictor #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .stat_clr(stat_clr), .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input bit [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int unsigned tag_of(input bit [31:0] pc);
    return (pc >> (2 + IW)) % (1 << TAG_W);
  endfunction

  function automatic bit m_hit(input bit [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_pred(input bit [31:0] pc);
    return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
  endfunction

  function automatic bit [31:0] m_pred_tgt(input bit [31:0] pc);
    return m_pred(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_br = 0; m_mis = 0;
  endtask

  task automatic set_ex(input bit v, input bit br, input bit [31:0] pc, input bit tk,
                        input bit [31:0] tgt, input bit ptk, input bit [31:0] ptgt);
    ex_valid = v; ex_branch = br; ex_pc = pc; ex_taken = tk;
    ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
  endtask

  // Called just after a falling edge with inputs set; checks outputs, advances the model.
  task automatic cycle();
    bit upd, mis;
    int i;
    #1;
    upd = ex_valid && ex_branch;
    mis = upd && ((ex_taken != ex_pred_taken) || (ex_taken && ex_pred_target != ex_target));
    check_val("pred_taken", {31'd0, pred_taken}, {31'd0, m_pred(if_pc)});
    check_val("pred_target", pred_target, m_pred_tgt(if_pc));
    check_val("redirect", {31'd0, redirect}, {31'd0, mis});
    if (upd) check_val("redirect_pc", redirect_pc, ex_taken ? ex_target : ex_pc + 32'd4);
    check_val("stat_branches", stat_branches, m_br);
    check_val("stat_mispredicts", stat_mispredicts, m_mis);
    if (upd) begin
      i = idx_of(ex_pc);
      if (m_hit(ex_pc)) begin
        if (ex_taken) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_tgt[i] = ex_target;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (ex_taken) begin
        m_valid[i] = 1; m_tag[i] = tag_of(ex_pc); m_tgt[i] = ex_target; m_ctr[i] = 2;
      end
    end
    if (stat_clr) begin
      m_br = 0; m_mis = 0;
    end else begin
      if (upd && m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
      if (mis && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
    end
    @(negedge clk);
  endtask

  function automatic bit [31:0] rand_pc();
    return 32'($urandom_range(0, 255)) << 2;
  endfunction

  initial begin
    bit [31:0] pc, tg;
    rst_n = 1'b0; if_pc = 32'h100; stat_clr = 1'b0;
    set_ex(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Reset state and first taken-mispredict
    if_pc = 32'h100; cycle();
    set_ex(1, 1, 32'h100, 1, 32'h80, 0, 32'h0); cycle();
    set_ex(1, 1, 32'h100, 1, 32'h80, 1, 32'h80); cycle();
    set_ex(1, 1, 32'h100, 1, 32'h80, 1, 32'h80); cycle();
    set_ex(1, 1, 32'h100, 0, 32'h80, 1, 32'h80); cycle();
    set_ex(1, 1, 32'h100, 0, 32'h80, 1, 32'h80); cycle();
    set_ex(0, 0, 0, 0, 0, 0, 0); cycle();

    // Direction and target mispredicts
    set_ex(1, 1, 32'h200, 0, 32'h300, 1, 32'h300); cycle();
    set_ex(1, 1, 32'h200, 1, 32'h340, 1, 32'h300); cycle();

    // Aliasing: 0x100 and 0x140 share index 0
    set_ex(1, 1, 32'h100, 1, 32'h80, 0, 32'h0); cycle();
    set_ex(1, 1, 32'h140, 1, 32'h500, 0, 32'h0); cycle();
    set_ex(0, 0, 0, 0, 0, 0, 0); if_pc = 32'h100; cycle();
    if_pc = 32'h140; cycle();
    set_ex(1, 1, 32'h100, 0, 32'h80, 0, 32'h0); cycle();
    set_ex(0, 1, 32'h140, 0, 32'h80, 1, 32'h0); cycle();
    set_ex(0, 0, 0, 0, 0, 0, 0); if_pc = 32'hFFFF_FFFC; cycle();

    // Counter saturation and clear priority
    force dut.br_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.br_cnt_q;
    m_br = 32'hFFFF_FFFF;
    #1;
    set_ex(1, 1, 32'h140, 1, 32'h500, 1, 32'h500); if_pc = 32'h140; cycle();
    set_ex(1, 1, 32'h140, 0, 32'h500, 1, 32'h500); stat_clr = 1'b1; cycle();
    set_ex(0, 0, 0, 0, 0, 0, 0); stat_clr = 1'b0; cycle();

    // Asynchronous reset mid-run
    set_ex(1, 1, 32'h140, 1, 32'h500, 0, 32'h0); cycle();
    set_ex(0, 0, 0, 0, 0, 0, 0); if_pc = 32'h140;
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    check_val("rst_branches", stat_branches, 32'd0);
    check_val("rst_mispredicts", stat_mispredicts, 32'd0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    cycle();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      pc = rand_pc();
      case ($urandom_range(0, 3))
        0: tg = 32'h80;
        1: tg = 32'h340;
        default: tg = rand_pc();
      endcase
      ex_valid  = ($urandom_range(0, 9) != 0);
      ex_branch = ($urandom_range(0, 4) != 0);
      ex_pc = pc; ex_taken = 1'($urandom_range(0, 1)); ex_target = tg;
      if ($urandom_range(0, 1) == 1) begin
        ex_pred_taken = m_pred(pc); ex_pred_target = m_pred_tgt(pc);
      end else begin
        ex_pred_taken = 1'($urandom_range(0, 1));
        ex_pred_target = ($urandom_range(0, 1) == 1) ? tg : rand_pc();
      end
      if_pc = ($urandom_range(0, 2) == 0) ? pc : rand_pc();
      stat_clr = ($urandom_range(0, 39) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
